// File: rtl/piso_tx.sv
// piso_tx: valid/ready parallel-in serial-out transmitter with a one-word holding buffer.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             done
);
`ifdef PISO_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(FRAME_LEN);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t               r_state, w_state_nx;
  logic [FRAME_LEN-1:0] r_frame, w_frame_nx, r_buf, w_buf_nx, w_fmt;
  logic [CW-1:0]        r_cnt, w_cnt_nx;
  logic                 r_full, w_full_nx, w_accept, w_last;
  logic [WIDTH-1:0]     w_ord;
  // Frames always leave from the top bit, so bit order is fixed once at load.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ord
    assign w_ord[i] = MSB_FIRST ? p_in[i] : p_in[WIDTH-1-i];
  end
`ifdef PISO_TX_PARITY_EN
  assign w_fmt = {w_ord, ^p_in};
`else
  assign w_fmt = w_ord;
`endif
  assign w_accept   = load_valid & ~r_full;
  assign w_last     = (r_state == SHIFT) && (r_cnt == CW'(FRAME_LEN - 1));
  assign load_ready = ~r_full;
  assign s_valid    = (r_state == SHIFT);
  assign s_out      = s_valid & r_frame[FRAME_LEN-1];
  assign done       = w_last;
  always_comb begin
    w_state_nx = r_state;
    w_frame_nx = r_frame;
    w_buf_nx   = r_buf;
    w_full_nx  = r_full;
    w_cnt_nx   = r_cnt;
    if (r_state == SHIFT) begin
      w_frame_nx = r_frame << 1;
      w_cnt_nx   = r_cnt + CW'(1);
    end
    if (r_state == IDLE || w_last) begin
      w_cnt_nx   = '0;
      w_state_nx = (r_full || w_accept) ? SHIFT : IDLE;
      if (r_full) begin
        w_frame_nx = r_buf;
        w_full_nx  = 1'b0;
      end else if (w_accept) begin
        w_frame_nx = w_fmt;
      end
    end else if (w_accept) begin
      w_buf_nx  = w_fmt;
      w_full_nx = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_frame <= '0;
      r_buf   <= '0;
      r_full  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_frame <= w_frame_nx;
      r_buf   <= w_buf_nx;
      r_full  <= w_full_nx;
      r_cnt   <= w_cnt_nx;
    end
  end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed bench for piso_tx, MSB-first and LSB-first instances side by side.
module tb_piso_tx;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = 9;
  localparam logic [FL-1:0] B5_M = 9'b1011_0101_1;
  localparam logic [FL-1:0] B5_L = 9'b1010_1101_1;
  localparam logic [FL-1:0] C3_M = 9'b0011_1100_0;
  localparam logic [FL-1:0] FF_M = 9'b1111_1111_0;
  localparam logic [FL-1:0] A5_M = 9'b1010_0101_0;
  localparam logic [FL-1:0] A5_L = 9'b1010_0101_0;
`else
  localparam int FL = 8;
  localparam logic [FL-1:0] B5_M = 8'b1011_0101;
  localparam logic [FL-1:0] B5_L = 8'b1010_1101;
  localparam logic [FL-1:0] C3_M = 8'b0011_1100;
  localparam logic [FL-1:0] FF_M = 8'b1111_1111;
  localparam logic [FL-1:0] A5_M = 8'b1010_0101;
  localparam logic [FL-1:0] A5_L = 8'b1010_0101;
`endif
  logic clk = 1'b0, rst = 1'b0, load_valid = 1'b0;
  logic [7:0] p_in = 8'h00;
  logic ready_m, sout_m, sval_m, done_m, ready_l, sout_l, sval_l, done_l;
  int checks = 0, failures = 0;
  logic [2*FL-1:0] cat;
  always #5 clk = ~clk;
  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .p_in(p_in), .load_valid(load_valid),
    .load_ready(ready_m), .s_out(sout_m), .s_valid(sval_m), .done(done_m));
  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .p_in(p_in), .load_valid(load_valid),
    .load_ready(ready_l), .s_out(sout_l), .s_valid(sval_l), .done(done_l));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_sval"}, {sval_m, sval_l}, 2'b00);
    check({tag, "_sout"}, {sout_m, sout_l}, 2'b00);
    check({tag, "_done"}, {done_m, done_l}, 2'b00);
    check({tag, "_ready"}, {ready_m, ready_l}, 2'b11);
  endtask
  task automatic run_frame(input string tag, input logic [7:0] w,
                           input logic [FL-1:0] em, input logic [FL-1:0] el);
    tick();
    p_in = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    p_in = ~w;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      check({tag, "_sval"}, {sval_m, sval_l}, 2'b11);
      check({tag, "_sout_m"}, sout_m, em[FL-1-k]);
      check({tag, "_sout_l"}, sout_l, el[FL-1-k]);
      check({tag, "_done"}, {done_m, done_l}, (k == FL - 1) ? 2'b11 : 2'b00);
      tick();
    end
    check_idle({tag, "_after"});
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b1;
    run_frame("single_b5", 8'hB5, B5_M, B5_L);
    tick();
    for (int k = 0; k < 6; k++) begin
      p_in = 8'(k * 37 + 5);
      @(negedge clk);
      check("hyg_sval", {sval_m, sval_l}, 2'b00);
      check("hyg_ready", {ready_m, ready_l}, 2'b11);
      tick();
    end
    cat = {B5_M, C3_M};
    p_in = 8'hB5;
    load_valid = 1'b1;
    tick();
    for (int k = 0; k < 2 * FL; k++) begin
      if (k == 0) p_in = 8'h3C;
      else if (k == FL + 1) load_valid = 1'b0;
      else p_in = 8'hFF;
      @(negedge clk);
      check("b2b_sval", sval_m, 1'b1);
      check("b2b_sout", sout_m, cat[2*FL-1-k]);
      check("b2b_done", done_m, (k == FL - 1 || k == 2 * FL - 1));
      check("b2b_ready", ready_m, (k == 0 || k == FL));
      tick();
    end
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      check("ff_sval", sval_m, 1'b1);
      check("ff_sout", sout_m, FF_M[FL-1-k]);
      check("ff_done", done_m, k == FL - 1);
      tick();
    end
    check_idle("ff_after");
    tick();
    p_in = 8'hB5;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_async_sval", {sval_m, sval_l}, 2'b00);
    check("rst_async_sout", {sout_m, sout_l}, 2'b00);
    check("rst_async_done", {done_m, done_l}, 2'b00);
    check("rst_async_ready", {ready_m, ready_l}, 2'b11);
    repeat (2) tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_idle("post_rst");
      tick();
    end
    run_frame("after_rst_a5", 8'hA5, A5_M, A5_L);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
